// File: rtl/noc_pkg.sv
// Shared NoC definitions: per-VC packet state, flit control bit positions
// and route bit meanings.
package noc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RC     = 2'd1,
        VA     = 2'd2,
        ACTIVE = 2'd3
    } vc_state_e;

    // Flit control bits are counted down from the flit MSB:
    // head = flit[FLIT_BITS-HEAD_BIT], tail = flit[FLIT_BITS-TAIL_BIT].
    localparam int HEAD_BIT = 1;
    localparam int TAIL_BIT = 2;
    // Destination field of a head flit starts at this bit.
    localparam int DEST_LSB = 0;

    // Route is a direction mask {y+, y-, x+, x-}; all zeros means local eject.
    localparam int X_MINUS = 0;
    localparam int X_PLUS  = 1;
    localparam int Y_MINUS = 2;
    localparam int Y_PLUS  = 3;

endpackage

// File: rtl/vc_fifo.sv
// Single-clock FIFO for one virtual channel. The front entry is read
// combinationally; a write lands in storage at the clock edge, so a flit is
// never visible at the front in the cycle it is written. A push into a full
// FIFO is taken only when a pop happens in the same cycle.
module vc_fifo
    import noc_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_front,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_wr_en;
    logic          w_rd_en;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);
    assign o_front = r_mem[r_rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Flit storage, written at the write pointer.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/input_vc_unit.sv
// Input-port virtual-channel front end: one FIFO per VC, per-VC packet state
// IDLE -> RC -> VA -> ACTIVE, routing/VC/switch request generation, flit
// emission and upstream credit return.
// Build option: define INPUT_VC_UNIT_ERR_EN to add the sticky ovf_err and
// proto_err flag ports.
//
// Handshakes: every *_req[v] is a level held while VC v waits; a *_gnt[v]
// bit counts only in a cycle where the matching *_req[v] is high, and the
// data travelling with the grant (rc_route, va_ovc) is taken in that cycle.
module input_vc_unit
    import noc_pkg::*;
#(
    parameter  int VCS       = 4,
    parameter  int DEPTH     = 4,
    parameter  int FLIT_BITS = 32,
    parameter  int DEST_BITS = 4,
    localparam int VC_BITS   = $clog2(VCS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [VC_BITS-1:0]       in_vc,
    input  logic [FLIT_BITS-1:0]     in_flit,
    output logic                     credit_valid,
    output logic [VC_BITS-1:0]       credit_vc,
`ifdef INPUT_VC_UNIT_ERR_EN
    output logic [VCS-1:0]           ovf_err,
    output logic [VCS-1:0]           proto_err,
`endif
    output logic [VCS-1:0]           rc_req,
    input  logic [VCS-1:0]           rc_gnt,
    output logic [VCS*DEST_BITS-1:0] rc_dest,
    input  logic [VCS*DEST_BITS-1:0] rc_route,
    output logic [VCS-1:0]           va_req,
    output logic [VCS*DEST_BITS-1:0] va_route,
    input  logic [VCS-1:0]           va_gnt,
    input  logic [VCS*VC_BITS-1:0]   va_ovc,
    output logic [VCS-1:0]           sa_req,
    input  logic [VCS-1:0]           sa_gnt,
    output logic                     out_valid,
    output logic [FLIT_BITS-1:0]     out_flit,
    output logic [DEST_BITS-1:0]     out_route,
    output logic [VC_BITS-1:0]       out_ovc
);

    vc_state_e [VCS-1:0]                r_state;
    vc_state_e [VCS-1:0]                w_state_nxt;
    logic [VCS-1:0][DEST_BITS-1:0]      r_route;
    logic [VCS-1:0][VC_BITS-1:0]        r_ovc;
    logic [VCS-1:0][FLIT_BITS-1:0]      w_front;
    logic [VCS-1:0]                     w_full;
    logic [VCS-1:0]                     w_empty;
    logic [VCS-1:0]                     w_push;
    logic [VCS-1:0]                     w_pop;
    logic [VCS-1:0]                     w_head;
    logic [VCS-1:0]                     w_tail;
    logic [VCS-1:0]                     w_sa_cand;
    logic [VCS-1:0]                     w_sa_sel;
    logic [VCS-1:0]                     w_disc_cand;
    logic [VCS-1:0]                     w_disc_sel;
    logic                               w_sa_any;
    logic                               w_disc_any;
    logic [VC_BITS-1:0]                 w_sa_idx;
    logic [VC_BITS-1:0]                 w_disc_idx;

    logic                               r_out_valid;
    logic [FLIT_BITS-1:0]               r_out_flit;
    logic [DEST_BITS-1:0]               r_out_route;
    logic [VC_BITS-1:0]                 r_out_ovc;
    logic                               r_credit_valid;
    logic [VC_BITS-1:0]                 r_credit_vc;

    genvar g;
    generate
        for (g = 0; g < VCS; g++) begin : g_vc
            assign w_push[g] = in_valid && (in_vc == VC_BITS'(g));
            assign w_head[g] = w_front[g][FLIT_BITS-HEAD_BIT];
            assign w_tail[g] = w_front[g][FLIT_BITS-TAIL_BIT];

            vc_fifo #(
                .W     (FLIT_BITS),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_push[g]),
                .i_pop   (w_pop[g]),
                .i_data  (in_flit),
                .o_front (w_front[g]),
                .o_full  (w_full[g]),
                .o_empty (w_empty[g])
            );
        end
    endgenerate

    assign va_route = r_route;

    // Per-VC request decode from the current state and FIFO front.
    always_comb begin
        rc_req      = '0;
        va_req      = '0;
        sa_req      = '0;
        rc_dest     = '0;
        w_disc_cand = '0;
        for (int v = 0; v < VCS; v++) begin
            case (r_state[v])
                IDLE:    w_disc_cand[v] = !w_empty[v] && !w_head[v];
                RC: begin
                    rc_req[v] = 1'b1;
                    rc_dest[v*DEST_BITS +: DEST_BITS] = w_front[v][DEST_LSB +: DEST_BITS];
                end
                VA:      va_req[v] = 1'b1;
                ACTIVE:  sa_req[v] = !w_empty[v];
                default: ;
            endcase
        end
    end

    // Pop selection: lowest-index granted SA pop owns the single output and
    // credit slot; a non-head discard in IDLE only goes when no SA pop does.
    always_comb begin
        w_sa_cand  = sa_req & sa_gnt;
        w_sa_sel   = '0;
        w_sa_any   = 1'b0;
        w_sa_idx   = '0;
        w_disc_sel = '0;
        w_disc_any = 1'b0;
        w_disc_idx = '0;
        for (int v = 0; v < VCS; v++) begin
            if (w_sa_cand[v] && !w_sa_any) begin
                w_sa_any    = 1'b1;
                w_sa_sel[v] = 1'b1;
                w_sa_idx    = VC_BITS'(v);
            end
        end
        for (int v = 0; v < VCS; v++) begin
            if (w_disc_cand[v] && !w_sa_any && !w_disc_any) begin
                w_disc_any    = 1'b1;
                w_disc_sel[v] = 1'b1;
                w_disc_idx    = VC_BITS'(v);
            end
        end
        w_pop = w_sa_sel | w_disc_sel;
    end

    // Next-state logic for every VC's packet state machine.
    always_comb begin
        w_state_nxt = r_state;
        for (int v = 0; v < VCS; v++) begin
            case (r_state[v])
                IDLE:    if (!w_empty[v] && w_head[v]) w_state_nxt[v] = RC;
                RC:      if (rc_gnt[v]) w_state_nxt[v] = VA;
                VA:      if (va_gnt[v]) w_state_nxt[v] = ACTIVE;
                ACTIVE:  if (w_sa_sel[v] && w_tail[v]) w_state_nxt[v] = IDLE;
                default: w_state_nxt[v] = IDLE;
            endcase
        end
    end

    // State register plus the route and output VC captured with each grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VCS; v++) begin
                r_state[v] <= IDLE;
                r_route[v] <= '0;
                r_ovc[v]   <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            for (int v = 0; v < VCS; v++) begin
                if (rc_req[v] && rc_gnt[v]) r_route[v] <= rc_route[v*DEST_BITS +: DEST_BITS];
                if (va_req[v] && va_gnt[v]) r_ovc[v] <= va_ovc[v*VC_BITS +: VC_BITS];
            end
        end
    end

    // Registered crossbar output and credit return, one cycle after the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_flit     <= '0;
            r_out_route    <= '0;
            r_out_ovc      <= '0;
            r_credit_valid <= 1'b0;
            r_credit_vc    <= '0;
        end else begin
            r_out_valid    <= w_sa_any;
            r_out_flit     <= w_sa_any ? w_front[w_sa_idx] : '0;
            r_out_route    <= w_sa_any ? r_route[w_sa_idx] : '0;
            r_out_ovc      <= w_sa_any ? r_ovc[w_sa_idx] : '0;
            r_credit_valid <= w_sa_any || w_disc_any;
            r_credit_vc    <= w_sa_any ? w_sa_idx : w_disc_idx;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_flit     = r_out_flit;
    assign out_route    = r_out_route;
    assign out_ovc      = r_out_ovc;
    assign credit_valid = r_credit_valid;
    assign credit_vc    = r_credit_vc;

`ifdef INPUT_VC_UNIT_ERR_EN
    logic [VCS-1:0] r_ovf_err;
    logic [VCS-1:0] r_proto_err;

    // Sticky flags: dropped writes and discarded non-head flits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err   <= '0;
            r_proto_err <= '0;
        end else begin
            r_ovf_err   <= r_ovf_err | (w_push & w_full & ~w_pop);
            r_proto_err <= r_proto_err | w_disc_sel;
        end
    end

    assign ovf_err   = r_ovf_err;
    assign proto_err = r_proto_err;
`endif

endmodule
